universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 94 +++++++++
 tb/tb_universal_shift_reg.sv | 121 ++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: parallel-load / shift / rotate register with a counted auto-shift sequencer
module universal_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             ser_in,
   input  logic             start,
   input  logic [CNT_W-1:0] shamt,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam logic [2:0] M_HOLD = 3'd0, M_LOAD = 3'd1, M_SHL = 3'd2, M_SHR = 3'd3,
                          M_ROL = 3'd4, M_ROR = 3'd5, M_ASR = 3'd6, M_CLR = 3'd7;
   state_t           state_q;
   logic [WIDTH-1:0] q_q, q_d;
   logic             ser_q, ser_d, busy_q, done_q, auto_ok;
   logic [2:0]       mode_q, op;
   logic [CNT_W-1:0] cnt_q, amt_d;
   assign q       = q_q;
   assign q_bar   = ~q_q;
   assign ser_out = ser_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign amt_d   = (shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shamt;
   assign auto_ok = start && (mode >= M_SHL) && (mode <= M_ASR);
   // One shift/rotate step of the active operation: latched mode while sequencing, live mode otherwise
   always_comb begin
      op    = (state_q == SHIFT) ? mode_q : mode;
      q_d   = q_q;
      ser_d = ser_q;
      case (op)
         M_SHL: begin q_d = {q_q[WIDTH-2:0], ser_in};       ser_d = q_q[WIDTH-1]; end
         M_SHR: begin q_d = {ser_in, q_q[WIDTH-1:1]};       ser_d = q_q[0];       end
         M_ROL: begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; ser_d = q_q[WIDTH-1]; end
         M_ROR: begin q_d = {q_q[0], q_q[WIDTH-1:1]};       ser_d = q_q[0];       end
         M_ASR: begin q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; ser_d = q_q[0];       end
         default: ;
      endcase
   end
   // Sequencer FSM and register; start outranks en, and DONE always falls back to IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         q_q     <= '0;
         ser_q   <= 1'b0;
         mode_q  <= M_HOLD;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (auto_ok) begin
                  mode_q  <= mode;
                  cnt_q   <= amt_d;
                  state_q <= (amt_d == '0) ? DONE : SHIFT;
                  busy_q  <= (amt_d != '0);
                  done_q  <= (amt_d == '0);
               end else if (en) begin
                  if (mode == M_LOAD) q_q <= d;
                  else if (mode == M_CLR) q_q <= '0;
                  else if (mode != M_HOLD) begin
                     q_q   <= q_d;
                     ser_q <= ser_d;
                  end
               end
            end
            SHIFT: begin
               q_q   <= q_d;
               ser_q <= ser_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed vectors checked through a cycle-tagged scoreboard
module tb_universal_shift_reg;
   logic       clk = 1'b0, reset = 1'b0, en = 1'b0, ser_in = 1'b0, start = 1'b0;
   logic [2:0] mode = 3'd0;
   logic [7:0] d = 8'h00;
   logic [3:0] shamt = 4'd0;
   logic [7:0] q, q_bar;
   logic       ser_out, busy, done;
   int         cyc = 0, chk_cnt = 0, pass_cnt = 0;
   event       sample_ev;

   typedef struct {
      int         cyc;
      string      name;
      logic [7:0] q;
      logic       ser, busy, done;
   } exp_t;
   exp_t sb[$];

   universal_shift_reg #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .ser_in(ser_in),
      .start(start), .shamt(shamt), .q(q), .q_bar(q_bar), .ser_out(ser_out),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string n, input logic [7:0] eq, input logic es,
                             input logic eb, input logic ed);
      exp_t e;
      e.cyc = cyc; e.name = n; e.q = eq; e.ser = es; e.busy = eb; e.done = ed;
      sb.push_back(e);
   endtask

   // Monitor: compares every expectation tagged for the current cycle
   initial forever begin
      @(negedge clk or sample_ev);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         chk_cnt++;
         if (e.cyc == cyc && q === e.q && q_bar === ~e.q && ser_out === e.ser &&
             busy === e.busy && done === e.done)
            pass_cnt++;
         else
            $display("FAIL %s cyc=%0d: got q=%h q_bar=%h ser=%b busy=%b done=%b, want q=%h q_bar=%h ser=%b busy=%b done=%b (tag %0d)",
                     e.name, cyc, q, q_bar, ser_out, busy, done, e.q, ~e.q, e.ser, e.busy, e.done, e.cyc);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tick(); tick();
      expect_out("reset", 8'h00, 0, 0, 0);
      reset = 1'b1;
      en = 1; mode = 3'b001; d = 8'hA5;           tick(); expect_out("load_a5", 8'hA5, 0, 0, 0);
      en = 0; d = 8'h00;                          tick(); expect_out("en0_hold", 8'hA5, 0, 0, 0);
      en = 1; mode = 3'b000;                      tick(); expect_out("mode_hold", 8'hA5, 0, 0, 0);
      mode = 3'b001; d = 8'h81;                   tick(); expect_out("load_81", 8'h81, 0, 0, 0);
      mode = 3'b100;                              tick(); expect_out("rol", 8'h03, 1, 0, 0);
      mode = 3'b110;                              tick(); expect_out("asr", 8'h01, 1, 0, 0);
      mode = 3'b010; ser_in = 1;                  tick(); expect_out("shl", 8'h03, 0, 0, 0);
      mode = 3'b011;                              tick(); expect_out("shr", 8'h81, 1, 0, 0);
      mode = 3'b101;                              tick(); expect_out("ror", 8'hC0, 1, 0, 0);
      mode = 3'b111;                              tick(); expect_out("clear", 8'h00, 1, 0, 0);
      mode = 3'b001; d = 8'hF0;                   tick(); expect_out("load_f0", 8'hF0, 1, 0, 0);
      start = 1; mode = 3'b011; shamt = 3; ser_in = 0;
      tick(); expect_out("shr3_accept", 8'hF0, 1, 1, 0);
      start = 0; en = 1; mode = 3'b111; d = 8'hFF; shamt = 7;
      tick(); expect_out("shr3_s1", 8'h78, 0, 1, 0);
      tick(); expect_out("shr3_s2", 8'h3C, 0, 1, 0);
      tick(); expect_out("shr3_done", 8'h1E, 0, 0, 1);
      tick(); expect_out("shr3_idle", 8'h1E, 0, 0, 0);
      en = 1; mode = 3'b001; d = 8'h00;           tick(); expect_out("load_00", 8'h00, 0, 0, 0);
      start = 1; mode = 3'b010; shamt = 15; ser_in = 1;
      tick(); expect_out("shl_clamp_accept", 8'h00, 0, 1, 0);
      start = 0; en = 0;
      for (int i = 1; i <= 8; i++) begin
         logic [8:0] v;
         v = (9'd1 << i) - 9'd1;
         tick(); expect_out($sformatf("shl_clamp_s%0d", i), v[7:0], 0, i < 8, i == 8);
      end
      tick(); expect_out("shl_clamp_idle", 8'hFF, 0, 0, 0);
      start = 1; mode = 3'b100; shamt = 0;        tick(); expect_out("zero_done", 8'hFF, 0, 0, 1);
      start = 0;                                  tick(); expect_out("zero_idle", 8'hFF, 0, 0, 0);
      start = 1; en = 1; mode = 3'b001; d = 8'h3C; shamt = 5;
      tick(); expect_out("start_load", 8'h3C, 0, 0, 0);
      start = 0; en = 0;                          tick(); expect_out("start_load_next", 8'h3C, 0, 0, 0);
      start = 1; mode = 3'b101; shamt = 5;        tick(); expect_out("ror5_accept", 8'h3C, 0, 1, 0);
      start = 0;                                  tick(); expect_out("ror5_s1", 8'h1E, 0, 1, 0);
      @(negedge clk); #2;
      reset = 0; #1;
      expect_out("async_reset", 8'h00, 0, 0, 0);
      ->sample_ev;
      tick(); expect_out("reset_hold1", 8'h00, 0, 0, 0);
      tick(); expect_out("reset_hold2", 8'h00, 0, 0, 0);
      reset = 1;
      tick(); expect_out("post_reset1", 8'h00, 0, 0, 0);
      tick(); expect_out("post_reset2", 8'h00, 0, 0, 0);
      en = 1; mode = 3'b001; d = 8'h5A;           tick(); expect_out("resume_load", 8'h5A, 0, 0, 0);
      en = 0;
      tick(); tick();
      if (sb.size() != 0) begin
         chk_cnt++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
